// File: rtl/bmp_ram_stream_reader_pkg.sv
// Shared constants, FSM encoding and the little-endian byte-insert helper for the BMP RAM stream reader.
package bmp_ram_stream_reader_pkg;

  localparam int unsigned BMP_ADDR_WIDTH = 32'd16;
  localparam int unsigned BMP_TOTAL_SIZE = 32'd65536;
  localparam int unsigned BMP_HDR_BYTES  = 32'd54;
  localparam logic [31:0] BMP_OFS_SIZE   = 32'd2;
  localparam logic [31:0] BMP_OFS_DATA   = 32'd10;
  localparam logic [31:0] BMP_OFS_W      = 32'd18;
  localparam logic [31:0] BMP_OFS_H      = 32'd22;
  localparam logic [31:0] BMP_OFS_BPP    = 32'd28;
  localparam logic [15:0] BMP_BPP_RGB    = 16'd24;
  localparam logic [15:0] BMP_SIG        = 16'h4D42;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } bmp_state_t;

  // Drops byte b into its little-endian lane when idx falls inside [base, base+n).
  function automatic logic [31:0] put_le_byte(input logic [31:0] field, input logic [31:0] idx,
                                              input logic [31:0] base, input logic [31:0] n,
                                              input logic [7:0] b);
    logic [31:0] r;
    logic [31:0] rel;
    r   = field;
    rel = idx - base;
    if (rel < n) begin
      r[{rel[1:0], 3'b000} +: 8] = b;
    end else begin
      r = field;
    end
    return r;
  endfunction

endpackage

// File: rtl/bmp_ram_stream_reader_header_parser.sv
// Assembles the BMP header fields from a byte stream and flags headers the reader cannot stream.
module bmp_header_parser
  import bmp_ram_stream_reader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = BMP_TOTAL_SIZE,
  parameter int unsigned HDR_BYTES = BMP_HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cap_en,
  input  logic [31:0] idx,
  input  logic [7:0]  byte_in,
  output logic [31:0] file_size,
  output logic [31:0] offset,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic        hdr_bad
);

  logic [15:0] sig_r;
  logic [15:0] bpp_r;

  // Field capture: each header byte lands in the lane of whichever field covers its index.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig_r     <= 16'h0000;
      bpp_r     <= 16'h0000;
      file_size <= 32'd0;
      offset    <= 32'd0;
      width     <= 32'd0;
      height    <= 32'd0;
    end else if (cap_en) begin
      sig_r     <= 16'(put_le_byte({16'h0000, sig_r}, idx, 32'd0, 32'd2, byte_in));
      bpp_r     <= 16'(put_le_byte({16'h0000, bpp_r}, idx, BMP_OFS_BPP, 32'd2, byte_in));
      file_size <= put_le_byte(file_size, idx, BMP_OFS_SIZE, 32'd4, byte_in);
      offset    <= put_le_byte(offset, idx, BMP_OFS_DATA, 32'd4, byte_in);
      width     <= put_le_byte(width, idx, BMP_OFS_W, 32'd4, byte_in);
      height    <= put_le_byte(height, idx, BMP_OFS_H, 32'd4, byte_in);
    end else begin
      sig_r     <= sig_r;
    end
  end

  // Pixel data must start past the header and inside a file that fits the RAM.
  assign hdr_bad = (sig_r != BMP_SIG) || (bpp_r != BMP_BPP_RGB) ||
                   (offset < HDR_BYTES) || (offset >= file_size) ||
                   (file_size > MEM_BYTES);

endmodule

// File: rtl/bmp_ram_stream_reader.sv
// Reads and validates the BMP header from the byte RAM, then streams pixel bytes over valid/ready.
module bmp_ram_stream_reader
  import bmp_ram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W    = BMP_ADDR_WIDTH,
  parameter int unsigned MEM_BYTES = BMP_TOTAL_SIZE,
  parameter int unsigned HDR_BYTES = BMP_HDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              RAM_ren,
  output logic              RAM_wen,
  output logic [ADDR_W-1:0] RAM_addr,
  input  logic [7:0]        RAM_out,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic [31:0]       img_width,
  output logic [31:0]       img_height,
  output logic              busy,
  output logic              done,
  output logic              hdr_err
);

  bmp_state_t        state_r, next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       addr32_s;
  logic [31:0]       file_size_s;
  logic [31:0]       offset_s;
  logic              hdr_bad_s;
  logic              rd_s;
  logic              ren_s;
  logic              hdr_end_s;
  logic              last_addr_s;
  logic [7:0]        pix_data_r;
  logic              pix_valid_r;
  logic              pix_last_r;
  logic              hdr_err_r;

  assign addr32_s    = 32'(addr_r);
  assign hdr_end_s   = (addr32_s == (HDR_BYTES - 32'd1));
  assign last_addr_s = (addr32_s == (file_size_s - 32'd1));

  bmp_header_parser #(
    .MEM_BYTES (MEM_BYTES),
    .HDR_BYTES (HDR_BYTES)
  ) u_parser (
    .clk       (clk),
    .rst       (rst),
    .clr       ((state_r == ST_IDLE) && start),
    .cap_en    (state_r == ST_HDR),
    .idx       (addr32_s),
    .byte_in   (RAM_out),
    .file_size (file_size_s),
    .offset    (offset_s),
    .width     (img_width),
    .height    (img_height),
    .hdr_bad   (hdr_bad_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and read strobe; the last byte is never re-read while it waits to be accepted.
  always_comb begin
    next_state_s = state_r;
    rd_s         = 1'b0;
    ren_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_HDR;
        else       next_state_s = ST_IDLE;
      end
      ST_HDR: begin
        ren_s = 1'b1;
        if (hdr_end_s) next_state_s = ST_CHECK;
        else           next_state_s = ST_HDR;
      end
      ST_CHECK: begin
        if (hdr_bad_s) next_state_s = ST_DONE;
        else           next_state_s = ST_STREAM;
      end
      ST_STREAM: begin
        rd_s  = (addr32_s < file_size_s) && !pix_last_r && (!pix_valid_r || pix_ready);
        ren_s = rd_s;
        if (pix_valid_r && pix_last_r && pix_ready) next_state_s = ST_DONE;
        else                                        next_state_s = ST_STREAM;
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Address counter, one-entry output register and sticky header error.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      pix_data_r  <= 8'h00;
      pix_valid_r <= 1'b0;
      pix_last_r  <= 1'b0;
      hdr_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pix_valid_r <= 1'b0;
          pix_last_r  <= 1'b0;
          if (start) begin
            addr_r    <= {ADDR_W{1'b0}};
            hdr_err_r <= 1'b0;
          end
        end
        ST_HDR: begin
          if (!hdr_end_s) addr_r <= addr_r + ADDR_W'(1'b1);
        end
        ST_CHECK: begin
          if (hdr_bad_s) hdr_err_r <= 1'b1;
          else           addr_r    <= ADDR_W'(offset_s);
        end
        ST_STREAM: begin
          if (rd_s) begin
            pix_data_r  <= RAM_out;
            pix_valid_r <= 1'b1;
            pix_last_r  <= last_addr_s;
            // Hold on the final address so RAM_addr stays inside the RAM.
            if (!last_addr_s) addr_r <= addr_r + ADDR_W'(1'b1);
          end else if (pix_valid_r && pix_ready) begin
            pix_valid_r <= 1'b0;
            pix_last_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          pix_valid_r <= 1'b0;
          pix_last_r  <= 1'b0;
        end
        default: begin
          pix_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign RAM_ren   = ren_s;
  assign RAM_wen   = 1'b0;
  assign RAM_addr  = addr_r;
  assign pix_data  = pix_data_r;
  assign pix_valid = pix_valid_r;
  assign pix_last  = pix_last_r;
  assign hdr_err   = hdr_err_r;
  assign busy      = (state_r == ST_HDR) || (state_r == ST_CHECK) || (state_r == ST_STREAM);
  assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_bmp_ram_stream_reader.sv
// Directed bench for bmp_ram_stream_reader: behavioural RAM, header images built in place, scenario tasks.
module tb_bmp_ram_stream_reader;

  localparam int AW  = 8;
  localparam int MEM = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pix_ready = 1'b1;
  logic          RAM_ren, RAM_wen, pix_valid, pix_last, busy, done, hdr_err;
  logic [AW-1:0] RAM_addr;
  logic [7:0]    RAM_out, pix_data;
  logic [31:0]   img_width, img_height;
  logic [7:0]    mem [0:255];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;
  assign RAM_out = mem[RAM_addr];

  bmp_ram_stream_reader #(.ADDR_W(AW), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .start(start), .RAM_ren(RAM_ren), .RAM_wen(RAM_wen),
    .RAM_addr(RAM_addr), .RAM_out(RAM_out), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .img_width(img_width),
    .img_height(img_height), .busy(busy), .done(done), .hdr_err(hdr_err)
  );

  function automatic logic [7:0] pix_val(input int a);
    return 8'(a * 3 + 7);
  endfunction

  task automatic build_image(input logic [7:0] s0, input logic [31:0] fsz,
                             input logic [31:0] ofs, input logic [15:0] bpp);
    for (int a = 0; a < 256; a++) mem[a] = pix_val(a);
    for (int a = 0; a < 54; a++) mem[a] = 8'h00;
    mem[0] = s0;
    mem[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      mem[2 + i]  = fsz[8*i +: 8];
      mem[10 + i] = ofs[8*i +: 8];
    end
    mem[18] = 8'd4;
    mem[22] = 8'd2;
    mem[26] = 8'd1;
    mem[28] = bpp[7:0];
    mem[29] = bpp[15:8];
  endtask

  // One complete start..done run with optional stall and stray start pulses.
  task automatic run_frame(input int n, input int offs, input bit exp_err, input int stall_byte,
                           input int stall_len, input bit poke, input string tag);
    int got, cyc, ren_cnt, stalled, done_cyc, exp_done;
    bit saw_valid, inv_bad, stall_bad, stall_now;
    logic [7:0] hold_data;
    logic [AW-1:0] hold_addr;
    got = 0; ren_cnt = 0; stalled = 0; done_cyc = -1;
    saw_valid = 1'b0; inv_bad = 1'b0; stall_bad = 1'b0;
    hold_data = 8'h00; hold_addr = '0;
    exp_done = exp_err ? 55 : 56 + n + stall_len;
    @(negedge clk); start = 1'b1; pix_ready = 1'b1;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      stall_now = (stall_len > 0) && pix_valid && (got == stall_byte) && (stalled < stall_len);
      pix_ready = !stall_now;
      start = poke && (cyc == 20 || cyc == 66);
      #1;
      if (cyc == 0) begin
        total++;
        if (RAM_ren !== 1'b1 || RAM_addr !== 8'd0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s first_read: ren=%b addr=%0d busy=%b want 1/0/1", tag, RAM_ren, RAM_addr, busy);
        end
      end
      if (RAM_wen !== 1'b0 || (RAM_ren && RAM_wen) || RAM_addr > 8'(MEM - 1)) inv_bad = 1'b1;
      if (RAM_ren) ren_cnt++;
      if (pix_valid) saw_valid = 1'b1;
      if (stall_now) begin
        if (stalled == 0) begin
          hold_data = pix_data;
          hold_addr = RAM_addr;
        end
        if (RAM_ren !== 1'b0 || RAM_addr !== hold_addr || pix_data !== hold_data) stall_bad = 1'b1;
        stalled++;
      end
      if (pix_valid && pix_ready) begin
        total++;
        if (pix_data !== pix_val(offs + got) || pix_last !== (got == n - 1)) begin
          bad++;
          $display("FAIL %s byte[%0d]: data=%02h last=%b want %02h/%b", tag, got, pix_data, pix_last,
                   pix_val(offs + got), (got == n - 1));
        end
        got++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    pix_ready = 1'b1;
    total++;
    if (done_cyc != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_done);
    end
    total++;
    if (got != n || (exp_err && saw_valid)) begin
      bad++;
      $display("FAIL %s byte_count: got %0d valid_seen=%b want %0d", tag, got, saw_valid, n);
    end
    total++;
    if (ren_cnt != 54 + n) begin
      bad++;
      $display("FAIL %s ren_cycles: got %0d want %0d", tag, ren_cnt, 54 + n);
    end
    total++;
    if (hdr_err !== exp_err || img_width !== 32'd4 || img_height !== 32'd2) begin
      bad++;
      $display("FAIL %s header: err=%b w=%0d h=%0d want %b/4/2", tag, hdr_err, img_width, img_height, exp_err);
    end
    total++;
    if (inv_bad || stall_bad) begin
      bad++;
      $display("FAIL %s invariants: ram=%b stall=%b want 0/0", tag, inv_bad, stall_bad);
    end
    if (stall_len > 0) begin
      total++;
      if (stalled != stall_len) begin
        bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalled, stall_len);
      end
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b want 0/0/0", tag, done, busy, pix_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (RAM_ren !== 1'b0 || RAM_wen !== 1'b0 || RAM_addr !== 8'd0 || pix_valid !== 1'b0 ||
        pix_last !== 1'b0 || pix_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        hdr_err !== 1'b0 || img_width !== 32'd0 || img_height !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: ren=%b addr=%0d valid=%b busy=%b done=%b err=%b w=%0d want all 0",
               RAM_ren, RAM_addr, pix_valid, busy, done, hdr_err, img_width);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream;
    build_image(8'h42, 32'd78, 32'd54, 16'd24);
    run_frame(24, 54, 1'b0, 0, 0, 1'b0, "stream");
  endtask

  task automatic test_bad_sig;
    build_image(8'h58, 32'd78, 32'd54, 16'd24);
    run_frame(0, 54, 1'b1, 0, 0, 1'b0, "bad_sig");
  endtask

  task automatic test_stall;
    build_image(8'h42, 32'd78, 32'd54, 16'd24);
    run_frame(24, 54, 1'b0, 4, 3, 1'b0, "stall");
  endtask

  task automatic test_rst_mid;
    int seen;
    bit hit, saw_done;
    build_image(8'h42, 32'd78, 32'd54, 16'd24);
    seen = 0; hit = 1'b0; saw_done = 1'b0;
    @(negedge clk); start = 1'b1; pix_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (done) saw_done = 1'b1;
      if (pix_valid) begin
        if (seen == 10) hit = 1'b1;
        else seen++;
      end
      if (!hit) @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_mid_reach: got %0d bytes want 10 before reset", seen);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || pix_valid !== 1'b0 || RAM_ren !== 1'b0 || done !== 1'b0 ||
        pix_last !== 1'b0 || img_width !== 32'd0 || saw_done) begin
      bad++;
      $display("FAIL rst_mid_abort: busy=%b valid=%b ren=%b done=%b w=%0d early_done=%b want all 0",
               busy, pix_valid, RAM_ren, done, img_width, saw_done);
    end
    rst = 1'b0;
    run_frame(24, 54, 1'b0, 0, 0, 1'b0, "replay");
  endtask

  task automatic test_start_ignored;
    build_image(8'h42, 32'd78, 32'd54, 16'd24);
    run_frame(24, 54, 1'b0, 0, 0, 1'b1, "start_poke");
  endtask

  task automatic test_hdr_checks;
    build_image(8'h42, 32'd129, 32'd54, 16'd24);
    run_frame(0, 54, 1'b1, 0, 0, 1'b0, "size_over");
    build_image(8'h42, 32'd78, 32'd54, 16'd8);
    run_frame(0, 54, 1'b1, 0, 0, 1'b0, "bpp8");
    build_image(8'h42, 32'd78, 32'd78, 16'd24);
    run_frame(0, 78, 1'b1, 0, 0, 1'b0, "ofs_eq_size");
    build_image(8'h42, 32'd78, 32'd53, 16'd24);
    run_frame(0, 53, 1'b1, 0, 0, 1'b0, "ofs_in_hdr");
  endtask

  task automatic test_full_mem;
    build_image(8'h42, 32'd128, 32'd54, 16'd24);
    run_frame(74, 54, 1'b0, 0, 0, 1'b0, "full_mem");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bad_sig();
    test_stall();
    test_rst_mid();
    test_start_ignored();
    test_hdr_checks();
    test_full_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
